// File: rtl/exec_sequencer.sv
// Execute-stage sequencer: routes one decoded instruction through
// optional memory access and register write-back, then signals done.
module exec_sequencer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [5:0]  bus,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE,
    MEM,
    WB,
    DONE
  } state_t;

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          mtr_q;
  logic          mtw_q;
  logic [4:0]    rd_q;
  logic [31:0]   alu_q;
  logic [31:0]   sd_q;
  logic [31:0]   rdata_q;
  logic          err_q;

  // alu_op is decoded by the ALU, not here
  logic unused_alu_op;
  assign unused_alu_op = ^bus[5:3];

  // Control FSM: latch on transfer, count MEM wait cycles, sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mtr_q   <= 1'b0;
      mtw_q   <= 1'b0;
      rd_q    <= '0;
      alu_q   <= '0;
      sd_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (issue_valid) begin
            mtr_q   <= bus[2];
            mtw_q   <= bus[1];
            rd_q    <= rd_addr;
            alu_q   <= alu_result;
            sd_q    <= store_data;
            rdata_q <= '0;
            cnt_q   <= '0;
            if (bus[0] && bus[1]) begin
              err_q   <= 1'b1;
              state_q <= DONE;
            end else if (bus[1]) begin
              state_q <= MEM;
            end else if (bus[0] && bus[2]) begin
              state_q <= MEM;
            end else if (bus[0]) begin
              state_q <= WB;
            end else begin
              state_q <= DONE;
            end
          end
        end
        MEM: begin
          if (mem_ack) begin
            if (mtw_q) begin
              state_q <= DONE;
            end else begin
              rdata_q <= mem_rdata;
              state_q <= WB;
            end
          end else if (cnt_q == CNT_LAST) begin
            err_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WB:      state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs decoded from registered state and latched fields
  always_comb begin
    issue_ready = (state_q == IDLE);
    mem_req     = (state_q == MEM);
    mem_we      = mem_req && mtw_q;
    mem_addr    = mem_req ? alu_q : '0;
    mem_wdata   = mem_we ? sd_q : '0;
    rf_we       = (state_q == WB) && (rd_q != 5'd0);
    rf_waddr    = (state_q == WB) ? rd_q : '0;
    rf_wdata    = '0;
    if (state_q == WB) begin
      rf_wdata = mtr_q ? rdata_q : alu_q;
    end
    done        = (state_q == DONE);
    err         = err_q;
  end

endmodule

// File: doc/exec_sequencer.md
EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, meaning the maximum number of cycles spent in MEM waiting for mem_ack before abort.
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port issue_valid, input, 1 bit: instruction offered.
REQ-005 SHALL have port issue_ready, output, 1 bit: sequencer can accept.
REQ-006 SHALL have port bus, input, 6 bits: control word from decode. [5:3] alu_op (ignored here), [2] mtr (memory-to-register), [1] mtw (memory write), [0] we (register write).
REQ-007 SHALL have port rd_addr, input, 5 bits: destination register.
REQ-008 SHALL have port alu_result, input, 32 bits: ALU output, used as write-back data or memory address.
REQ-009 SHALL have port store_data, input, 32 bits: SW data.
REQ-010 SHALL have port mem_req, output, 1 bit; port mem_we, output, 1 bit; port mem_addr, output, 32 bits; port mem_wdata, output, 32 bits; port mem_rdata, input, 32 bits; port mem_ack, input, 1 bit.
REQ-011 SHALL have port rf_we, output, 1 bit; port rf_waddr, output, 5 bits; port rf_wdata, output, 32 bits.
REQ-012 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-013 SHALL have port err, output, 1 bit: sticky error flag.

Function
REQ-014 SHALL implement FSM states IDLE, MEM, WB, DONE, with all outputs decoded from registered state and latched fields.
REQ-015 SHALL assert issue_ready only in IDLE; a transfer occurs when issue_valid and issue_ready are both high on a rising edge.
REQ-016 SHALL latch bus, rd_addr, alu_result and store_data on transfer; inputs SHALL be ignored at all other times.
REQ-017 SHALL route from IDLE on transfer as follows, evaluated in this order:
  - we=1 and mtw=1: illegal; set err, go to DONE.
  - mtw=1: go to MEM as a write.
  - we=1 and mtr=1: go to MEM as a read.
  - we=1 and mtr=0: go to WB.
  - otherwise (NOP/jump, includes mtr=1 with we=0 and mtw=0): go to DONE.
REQ-018 SHALL, in MEM, hold mem_req=1, mem_addr=latched alu_result, mem_we=latched mtw, mem_wdata=latched store_data (zero on read), all stable until mem_ack.
REQ-019 SHALL, on mem_ack in MEM, go to DONE for a write; for a read, capture mem_rdata and go to WB.
REQ-020 SHALL count cycles in MEM with a counter cleared on MEM entry; if MEM_TIMEOUT cycles elapse without mem_ack, set err, drop mem_req and go to DONE with no register write.
REQ-021 SHALL let mem_ack win over timeout when both occur in the same cycle.
REQ-022 SHALL ignore mem_ack outside MEM.
REQ-023 SHALL, in WB, assert rf_we for exactly one cycle with rf_waddr=latched rd_addr and rf_wdata=captured mem_rdata if mtr, else latched alu_result; then go to DONE.
REQ-024 SHALL suppress rf_we when rd_addr=0 while still passing through WB.
REQ-025 SHALL assert done for exactly one cycle in DONE, then go to IDLE.
REQ-026 SHALL keep err high once set, until reset.
REQ-027 SHALL meet these latencies from a transfer at edge N:
  - R-type: rf_we high in cycle N+1, done in N+2, issue_ready in N+3.
  - NOP: done in N+1.
  - Memory operation: mem_req from N+1.

Reset
REQ-028 SHALL, while rst_n=0, immediately force state IDLE and the MEM counter to 0.
REQ-029 SHALL, while rst_n=0, immediately force mem_req, mem_we, rf_we, done, err to 0, all data/address outputs to 0, and all latched fields to 0; this includes reset mid-MEM (mem_req drops without waiting for the clock).
REQ-030 SHALL take issue_ready=1 after reset release.

Verification
REQ-031 SHALL cover an R-type transfer with bus=010001, rd=3, alu_result=0x0000_00AA -> rf_we one cycle at N+1, rf_waddr=3, rf_wdata=0xAA; done at N+2; no mem_req.
REQ-032 SHALL cover SW with bus=000110, alu_result=0x40, store_data=0xDEAD_BEEF and mem_ack after 3 cycles -> mem_req/mem_we high with addr 0x40, data 0xDEADBEEF; no rf_we; done one cycle after ack.
REQ-033 SHALL cover LW with bus=000101, rd=7, alu_result=0x80, mem_rdata=0x1234_5678 acked after 1 cycle -> rf_we with rf_waddr=7, rf_wdata=0x12345678, then done.
REQ-034 SHALL cover the illegal and zero-register cases: bus=000011 -> err=1 and done at N+1 with no mem_req and no rf_we; bus=010001 with rd=0 -> no rf_we, done at N+2.
REQ-035 SHALL cover timeout and reset: LW with mem_ack never asserted -> mem_req held 15 cycles, then err=1, done, no rf_we; mem_ack coincident with the final timeout cycle -> normal completion, err stays 0.
REQ-036 SHALL cover rst_n low mid-MEM -> mem_req=0 asynchronously and issue_ready=1 after release.
